// File: rtl/shifter_spi_master_if.sv
// Bundle between the datapath requester, the shifter SPI master and the shifter slaves.
interface shifter_spi_master_if #(
  parameter int unsigned RegisterSize = 8,
  parameter int unsigned OpWidth      = 4,
  parameter int unsigned NumSlaves    = 1
);
  localparam int unsigned ShiftW = $clog2(RegisterSize);
  localparam int unsigned SelW   = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  logic                    i_start;
  logic [OpWidth-1:0]      i_op_code;
  logic [RegisterSize-1:0] i_operand;
  logic [ShiftW-1:0]       i_shift_amount;
  logic [SelW-1:0]         i_slave_sel;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_error;
  logic [RegisterSize-1:0] o_result;
  logic [NumSlaves-1:0]    o_nss;
  logic                    o_mosi;
  logic                    i_miso;

  modport master (
    input  i_start, i_op_code, i_operand, i_shift_amount, i_slave_sel, i_miso,
    output o_busy, o_done, o_error, o_result, o_nss, o_mosi
  );

  modport slave (
    output i_start, i_op_code, i_operand, i_shift_amount, i_slave_sel, i_miso,
    input  o_busy, o_done, o_error, o_result, o_nss, o_mosi
  );
endinterface

// File: rtl/shifter_spi_master.sv
// Initiator of the shifter serial link: sends {shift, operand, op} LSB first,
// waits for slave ready, then shifts the rotated result back in.
module shifter_spi_master #(
  parameter int unsigned RegisterSize  = 8,
  parameter int unsigned OpWidth       = 4,
  parameter int unsigned NumSlaves     = 1,
  parameter int unsigned TimeoutCycles = 16
) (
  input logic                  i_clock,
  input logic                  i_reset,
  shifter_spi_master_if.master bus
);
  localparam int unsigned ShiftW  = $clog2(RegisterSize);
  localparam int unsigned PktW    = ShiftW + RegisterSize + OpWidth;
  localparam int unsigned MaxCnt  = (PktW > RegisterSize) ? PktW : RegisterSize;
  localparam int unsigned BitCntW = $clog2(MaxCnt);
  localparam int unsigned ToCntW  = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TRANSMIT,
    S_WAIT,
    S_RECEIVE,
    S_DONE
  } state_e;

  state_e                  state_q;
  logic [PktW-1:0]         pkt_q;
  logic [BitCntW-1:0]      bit_cnt_q;
  logic [ToCntW-1:0]       to_cnt_q;
  logic [ToCntW-1:0]       to_cnt_d;
  logic [NumSlaves-1:0]    nss_q;
  logic [NumSlaves-1:0]    nss_sel_d;
  logic                    mosi_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    error_q;
  logic [RegisterSize-1:0] result_q;

  // An out-of-range slave index decodes to no select at all, so the frame times out.
  always_comb begin
    nss_sel_d = '1;
    for (int unsigned i = 0; i < NumSlaves; i++) begin
      if (32'(bus.i_slave_sel) == i) nss_sel_d[i] = 1'b0;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      pkt_q     <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
      nss_q     <= '1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            pkt_q   <= {bus.i_shift_amount, bus.i_operand, bus.i_op_code};
            nss_q   <= nss_sel_d;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          mosi_q    <= pkt_q[0];
          pkt_q     <= pkt_q >> 1;
          bit_cnt_q <= '0;
          state_q   <= S_TRANSMIT;
        end
        S_TRANSMIT: begin
          if (bit_cnt_q == BitCntW'(PktW - 1)) begin
            mosi_q   <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= S_WAIT;
          end else begin
            mosi_q    <= pkt_q[0];
            pkt_q     <= pkt_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.i_miso) begin
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_RECEIVE;
          end else if (to_cnt_d == ToCntW'(TimeoutCycles)) begin
            to_cnt_q <= '0;
            nss_q    <= '1;
            result_q <= '0;
            error_q  <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        S_RECEIVE: begin
          // First received bit ends up in bit 0 after RegisterSize shifts.
          result_q <= {bus.i_miso, result_q[RegisterSize-1:1]};
          if (bit_cnt_q == BitCntW'(RegisterSize - 1)) begin
            nss_q   <= '1;
            error_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_nss    = nss_q;
  assign bus.o_mosi   = mosi_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_done   = done_q;
  assign bus.o_error  = error_q;
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_shifter_spi_master.sv
// Directed bench for shifter_spi_master with a behavioural rotate slave on the link.
module tb_shifter_spi_master;
  localparam int unsigned RS = 8;
  localparam int unsigned OW = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned PW = 15;
  localparam logic [OW-1:0] OP_SHL = 4'd0;
  localparam logic [OW-1:0] OP_SHR = 4'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shifter_spi_master_if #(.RegisterSize(RS), .OpWidth(OW), .NumSlaves(NS)) bus ();

  shifter_spi_master #(
    .RegisterSize(RS),
    .OpWidth(OW),
    .NumSlaves(NS),
    .TimeoutCycles(TO)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus(bus)
  );

  int nvec  = 0;
  int nfail = 0;

  typedef enum {SL_IDLE, SL_RX, SL_GAP, SL_READY, SL_DATA} sl_e;
  sl_e         sl_ph;
  int          sl_cnt;
  logic [PW-1:0] sl_pkt;
  logic [RS-1:0] sl_res;
  logic        sl_en;
  int unsigned sl_idx;

  function automatic logic [RS-1:0] slave_rot(input logic [PW-1:0] p);
    logic [15:0] t;
    logic [RS-1:0] v;
    v = p[11:4];
    if (p[3:0] == OP_SHL) begin
      t = {v, v} << p[14:12];
      return t[15:8];
    end else begin
      t = {v, v} >> p[14:12];
      return t[7:0];
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sl_ph  <= SL_IDLE;
      sl_cnt <= 0;
    end else begin
      case (sl_ph)
        SL_IDLE: if (sl_en && bus.o_nss[sl_idx] == 1'b0 && bus.o_mosi) begin
          sl_ph  <= SL_RX;
          sl_cnt <= 0;
        end
        SL_RX: begin
          sl_pkt[sl_cnt] <= bus.o_mosi;
          if (sl_cnt == PW - 1) sl_ph <= SL_GAP;
          else sl_cnt <= sl_cnt + 1;
        end
        SL_GAP: begin
          sl_res <= slave_rot(sl_pkt);
          sl_ph  <= SL_READY;
        end
        SL_READY: begin
          sl_ph  <= SL_DATA;
          sl_cnt <= 0;
        end
        SL_DATA: begin
          if (sl_cnt == RS - 1) sl_ph <= SL_IDLE;
          else sl_cnt <= sl_cnt + 1;
        end
        default: sl_ph <= SL_IDLE;
      endcase
    end
  end

  // Outside WAIT/RECEIVE an enabled slave drives 1, which the master must ignore.
  assign bus.i_miso = (sl_ph == SL_GAP)   ? 1'b0 :
                      (sl_ph == SL_READY) ? 1'b1 :
                      (sl_ph == SL_DATA)  ? sl_res[sl_cnt] : sl_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic xfer(input string tag, input logic [3:0] op, input logic [7:0] opnd,
                      input logic [2:0] sh, input logic [1:0] sel, input logic [7:0] exp_res,
                      input logic exp_err, input int exp_cyc, input logic [14:0] exp_pkt,
                      input int glitch_cyc);
    int cyc;
    logic nss_bad;
    logic [3:0] exp_nss;
    exp_nss = 4'hF & ~(4'b0001 << sel);
    sl_idx = sel;
    bus.i_start        = 1'b1;
    bus.i_op_code      = op;
    bus.i_operand      = opnd;
    bus.i_shift_amount = sh;
    bus.i_slave_sel    = sel;
    @(negedge clk);
    cyc = 1;
    bus.i_start = 1'b0;
    chk({tag, ".start_busy"}, bus.o_busy, 1);
    chk({tag, ".start_mosi"}, bus.o_mosi, 1);
    nss_bad = 1'b0;
    while (!bus.o_done && cyc < 80) begin
      if (bus.o_nss !== exp_nss) nss_bad = 1'b1;
      if (cyc == glitch_cyc) begin
        bus.i_start        = 1'b1;
        bus.i_operand      = 8'hFF;
        bus.i_op_code      = OP_SHR;
        bus.i_shift_amount = 3'd7;
        bus.i_slave_sel    = sel + 2'd1;
      end else if (cyc == glitch_cyc + 1) begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".nss_during"}, nss_bad, 0);
    chk({tag, ".done_cycle"}, cyc, exp_cyc);
    chk({tag, ".done"}, bus.o_done, 1);
    chk({tag, ".done_busy"}, bus.o_busy, 1);
    chk({tag, ".done_nss"}, bus.o_nss, 4'hF);
    chk({tag, ".error"}, bus.o_error, exp_err);
    chk({tag, ".result"}, bus.o_result, exp_res);
    if (exp_err == 1'b0) chk({tag, ".mosi_pkt"}, sl_pkt, exp_pkt);
    @(negedge clk);
    chk({tag, ".idle_done"}, bus.o_done, 0);
    chk({tag, ".idle_busy"}, bus.o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_done;
    bus.i_start        = 1'b0;
    bus.i_op_code      = '0;
    bus.i_operand      = '0;
    bus.i_shift_amount = '0;
    bus.i_slave_sel    = '0;
    sl_en  = 1'b1;
    sl_idx = 0;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.nss", bus.o_nss, 4'hF);
    chk("rst.mosi", bus.o_mosi, 0);
    chk("rst.busy", bus.o_busy, 0);
    chk("rst.done", bus.o_done, 0);
    chk("rst.error", bus.o_error, 0);
    chk("rst.result", bus.o_result, 0);
    rst = 1'b0;
    @(negedge clk);

    xfer("shl96", OP_SHL, 8'h96, 3'd3, 2'd0, 8'hB4, 1'b0, 27, 15'h3960, -1);
    xfer("shr01", OP_SHR, 8'h01, 3'd1, 2'd0, 8'h80, 1'b0, 27, 15'h1011, -1);
    xfer("shl5a", OP_SHL, 8'h5A, 3'd0, 2'd2, 8'h5A, 1'b0, 27, 15'h05A0, -1);
    xfer("glitch", OP_SHL, 8'hC3, 3'd1, 2'd3, 8'h87, 1'b0, 27, 15'h1C30, 6);
    xfer("b2b", OP_SHR, 8'hF0, 3'd4, 2'd1, 8'h0F, 1'b0, 27, 15'h4F01, -1);

    sl_en = 1'b0;
    xfer("tmo", OP_SHL, 8'h33, 3'd2, 2'd0, 8'h00, 1'b1, PW + 2 + TO, 15'h0000, -1);
    sl_en = 1'b1;

    // Reset while receiving the result.
    sl_idx = 1;
    bus.i_start        = 1'b1;
    bus.i_op_code      = OP_SHL;
    bus.i_operand      = 8'h0F;
    bus.i_shift_amount = 3'd2;
    bus.i_slave_sel    = 2'd1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (PW + 5) @(negedge clk);
    chk("mrst.recv_busy", bus.o_busy, 1);
    chk("mrst.recv_nss", bus.o_nss, 4'hD);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.nss", bus.o_nss, 4'hF);
    chk("mrst.mosi", bus.o_mosi, 0);
    chk("mrst.busy", bus.o_busy, 0);
    chk("mrst.done", bus.o_done, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_done) saw_done = 1'b1;
    end
    chk("mrst.no_done", saw_done, 0);
    xfer("post_rst", OP_SHR, 8'h0F, 3'd2, 2'd1, 8'hC3, 1'b0, 27, 15'h20F1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
